// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from an sfifo and sends each one LSB-first
// as start, data, optional parity and stop bits, with each bit lasting DIVIDE clocks.
module fifo_uart_tx #(
    parameter int WIDTH    = 8,
    parameter int DIVIDE   = 4,
    parameter int PARITY   = 0,
    parameter int STOPBITS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             empty,
    input  logic [WIDTH-1:0] rdata,
    output logic             read,
    output logic             tx,
    output logic             busy
);

    localparam int DIVW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
    localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(DIVIDE - 1);
    localparam logic [CNTW-1:0] BIT_LAST  = CNTW'(WIDTH - 1);
    localparam logic [CNTW-1:0] STOP_LAST = CNTW'(STOPBITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state;
    logic [DIVW-1:0]  divcnt;
    logic [CNTW-1:0]  bitcnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] shnext;
    logic             bit_end;
    logic             parity_bit;

    assign read       = (state == S_IDLE) & ~empty & en & ~reset;
    assign bit_end    = (divcnt == DIV_LAST);
    assign shnext     = shreg >> 1;
    // Parity comes from the latched word because shreg is consumed while shifting.
    assign parity_bit = (PARITY == 2) ? ~(^word) : (^word);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            tx     <= 1'b1;
            busy   <= 1'b0;
            divcnt <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            word   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (read) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    shreg  <= rdata;
                    word   <= rdata;
                    tx     <= 1'b0;
                    divcnt <= '0;
                    state  <= S_START;
                end
                S_START: begin
                    if (bit_end) begin
                        divcnt <= '0;
                        bitcnt <= '0;
                        tx     <= shreg[0];
                        state  <= S_DATA;
                    end else begin
                        divcnt <= divcnt + DIVW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        divcnt <= '0;
                        if (bitcnt == BIT_LAST) begin
                            bitcnt <= '0;
                            if (PARITY != 0) begin
                                tx    <= parity_bit;
                                state <= S_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            bitcnt <= bitcnt + CNTW'(1);
                            shreg  <= shnext;
                            tx     <= shnext[0];
                        end
                    end else begin
                        divcnt <= divcnt + DIVW'(1);
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        divcnt <= '0;
                        bitcnt <= '0;
                        tx     <= 1'b1;
                        state  <= S_STOP;
                    end else begin
                        divcnt <= divcnt + DIVW'(1);
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        divcnt <= '0;
                        if (bitcnt == STOP_LAST) begin
                            bitcnt <= '0;
                            busy   <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            bitcnt <= bitcnt + CNTW'(1);
                        end
                    end else begin
                        divcnt <= divcnt + DIVW'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a small FIFO model feeds the main instance,
// and three extra instances cover even parity, odd parity and two stop bits.
module tb_fifo_uart_tx;

    logic clk = 1'b0;
    logic reset;
    logic en;

    logic       empty, read, tx, busy;
    logic [7:0] rdata;
    logic [7:0] mem [0:3];
    logic [7:0] wpos = 8'd0;
    logic [7:0] rpos = 8'd0;

    logic       pe_empty, pe_read, pe_tx, pe_busy;
    logic       po_empty, po_read, po_tx, po_busy;
    logic       s2_empty, s2_read, s2_tx, s2_busy;
    logic [7:0] par_rdata = 8'h07;
    logic [7:0] s2_rdata  = 8'h00;

    int checkCount = 0;
    int passCount  = 0;
    int cycle      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // FIFO model: rdata appears the cycle after the edge that sampled read.
    assign empty = (wpos == rpos);
    always @(posedge clk) begin
        if (read) begin
            rdata <= mem[rpos[1:0]];
            rpos  <= rpos + 8'd1;
        end
    end

    fifo_uart_tx #(.WIDTH(8), .DIVIDE(4), .PARITY(0), .STOPBITS(1)) dut (
        .clk(clk), .reset(reset), .en(en), .empty(empty), .rdata(rdata),
        .read(read), .tx(tx), .busy(busy)
    );
    fifo_uart_tx #(.WIDTH(8), .DIVIDE(4), .PARITY(1), .STOPBITS(1)) dut_pe (
        .clk(clk), .reset(reset), .en(en), .empty(pe_empty), .rdata(par_rdata),
        .read(pe_read), .tx(pe_tx), .busy(pe_busy)
    );
    fifo_uart_tx #(.WIDTH(8), .DIVIDE(4), .PARITY(2), .STOPBITS(1)) dut_po (
        .clk(clk), .reset(reset), .en(en), .empty(po_empty), .rdata(par_rdata),
        .read(po_read), .tx(po_tx), .busy(po_busy)
    );
    fifo_uart_tx #(.WIDTH(8), .DIVIDE(4), .PARITY(0), .STOPBITS(2)) dut_s2 (
        .clk(clk), .reset(reset), .en(en), .empty(s2_empty), .rdata(s2_rdata),
        .read(s2_read), .tx(s2_tx), .busy(s2_busy)
    );

    function automatic logic txOf(input int i);
        case (i)
            1:       return pe_tx;
            2:       return po_tx;
            3:       return s2_tx;
            default: return tx;
        endcase
    endfunction

    function automatic logic busyOf(input int i);
        case (i)
            1:       return pe_busy;
            2:       return po_busy;
            3:       return s2_busy;
            default: return busy;
        endcase
    endfunction

    function automatic logic readOf(input int i);
        case (i)
            1:       return pe_read;
            2:       return po_read;
            3:       return s2_read;
            default: return read;
        endcase
    endfunction

    function automatic logic [7:0] fifoCount();
        return wpos - rpos;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic enable);
        reset = rst;
        en    = enable;
    endtask

    task automatic pushWord(input logic [7:0] d);
        mem[wpos[1:0]] = d;
        wpos = wpos + 8'd1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        assert (actual === expected) passCount++;
        else $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    // Called on the sample where read is high; walks LOAD plus nbits serial bits of 4 clocks.
    task automatic checkFrame(input int inst, input string tag, input logic [15:0] bits,
                              input int nbits, input logic dropEn);
        logic [15:0] got;
        int unstable;
        int notBusy;
        int reads;
        got      = '0;
        unstable = 0;
        notBusy  = 0;
        reads    = 0;
        step();
        pe_empty = 1'b1;
        po_empty = 1'b1;
        s2_empty = 1'b1;
        if (dropEn) en = 1'b0;
        if (busyOf(inst) !== 1'b1) notBusy++;
        if (readOf(inst) !== 1'b0) reads++;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                if (c == 0) got[b] = txOf(inst);
                else if (txOf(inst) !== got[b]) unstable++;
                if (busyOf(inst) !== 1'b1) notBusy++;
                if (readOf(inst) !== 1'b0) reads++;
            end
        end
        checkOutput({tag, " line bits"}, 32'(got), 32'(bits));
        checkOutput({tag, " bit hold"}, unstable, 0);
        checkOutput({tag, " busy gaps"}, notBusy, 0);
        checkOutput({tag, " reads in frame"}, reads, 0);
    endtask

    initial begin
        int bad_tx;
        int bad_read;
        int bad_busy;
        int reads;
        int t0;

        pe_empty = 1'b1;
        po_empty = 1'b1;
        s2_empty = 1'b1;
        applyStimulus(1'b1, 1'b1);
        step();
        checkOutput("reset read", 32'(read), 32'd0);
        step();
        checkOutput("reset tx", 32'(tx), 32'd1);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset aux tx", 32'({pe_tx, po_tx, s2_tx}), 32'h7);
        checkOutput("reset aux busy", 32'({pe_busy, po_busy, s2_busy}), 32'h0);

        applyStimulus(1'b0, 1'b1);
        bad_tx = 0; bad_read = 0; bad_busy = 0;
        repeat (20) begin
            step();
            if (tx !== 1'b1) bad_tx++;
            if (read !== 1'b0) bad_read++;
            if (busy !== 1'b0) bad_busy++;
        end
        checkOutput("idle tx", bad_tx, 0);
        checkOutput("idle read", bad_read, 0);
        checkOutput("idle busy", bad_busy, 0);

        pushWord(8'hA5);
        #1;
        checkOutput("a5 read", 32'(read), 32'd1);
        checkFrame(0, "a5", {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 1'b0);
        step();
        checkOutput("a5 busy end", 32'(busy), 32'd0);
        checkOutput("a5 read end", 32'(read), 32'd0);
        checkOutput("a5 rpos", 32'(rpos), 32'd1);
        checkOutput("a5 wpos", 32'(wpos), 32'd1);

        pushWord(8'h12);
        pushWord(8'h34);
        pushWord(8'h56);
        #1;
        checkOutput("b2b read 1", 32'(read), 32'd1);
        t0 = cycle;
        checkFrame(0, "b2b 12", {6'b0, 1'b1, 8'h12, 1'b0}, 10, 1'b0);
        step();
        checkOutput("b2b read 2", 32'(read), 32'd1);
        checkOutput("b2b spacing 1", cycle - t0, 42);
        t0 = cycle;
        checkFrame(0, "b2b 34", {6'b0, 1'b1, 8'h34, 1'b0}, 10, 1'b0);
        step();
        checkOutput("b2b read 3", 32'(read), 32'd1);
        checkOutput("b2b spacing 2", cycle - t0, 42);
        checkFrame(0, "b2b 56", {6'b0, 1'b1, 8'h56, 1'b0}, 10, 1'b0);
        step();
        checkOutput("b2b busy end", 32'(busy), 32'd0);
        reads = 0;
        repeat (10) begin
            if (read !== 1'b0) reads++;
            step();
        end
        checkOutput("b2b no extra read", reads, 0);

        pe_empty = 1'b0;
        #1;
        checkOutput("even read", 32'(pe_read), 32'd1);
        checkFrame(1, "even 07", {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 1'b0);
        step();
        checkOutput("even busy end", 32'(pe_busy), 32'd0);

        po_empty = 1'b0;
        #1;
        checkOutput("odd read", 32'(po_read), 32'd1);
        checkFrame(2, "odd 07", {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 1'b0);
        step();
        checkOutput("odd busy end", 32'(po_busy), 32'd0);

        s2_empty = 1'b0;
        #1;
        checkOutput("stop2 read", 32'(s2_read), 32'd1);
        checkFrame(3, "stop2 00", {5'b0, 2'b11, 8'h00, 1'b0}, 11, 1'b0);
        step();
        checkOutput("stop2 busy end", 32'(s2_busy), 32'd0);

        pushWord(8'hA5);
        #1;
        checkOutput("rst a5 read", 32'(read), 32'd1);
        step();
        repeat (18) step();
        checkOutput("rst a5 bit3", 32'(tx), 32'd0);
        pushWord(8'h3C);
        applyStimulus(1'b1, 1'b1);
        step();
        checkOutput("rst tx", 32'(tx), 32'd1);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst read", 32'(read), 32'd0);
        checkOutput("rst fifo count", 32'(fifoCount()), 32'd1);
        applyStimulus(1'b0, 1'b1);
        #1;
        checkOutput("rst 3c read", 32'(read), 32'd1);
        checkFrame(0, "rst 3c", {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 1'b0);
        step();
        checkOutput("rst 3c busy end", 32'(busy), 32'd0);

        applyStimulus(1'b0, 1'b0);
        pushWord(8'h81);
        pushWord(8'h42);
        reads = 0;
        repeat (50) begin
            step();
            if (read !== 1'b0) reads++;
        end
        checkOutput("en off reads", reads, 0);
        checkOutput("en off fifo count", 32'(fifoCount()), 32'd2);
        en = 1'b1;
        #1;
        checkOutput("en on read", 32'(read), 32'd1);
        checkFrame(0, "en 81", {6'b0, 1'b1, 8'h81, 1'b0}, 10, 1'b1);
        step();
        checkOutput("en 81 busy end", 32'(busy), 32'd0);
        reads = 0;
        repeat (20) begin
            if (read !== 1'b0) reads++;
            step();
        end
        checkOutput("en drop no read", reads, 0);
        checkOutput("en drop fifo count", 32'(fifoCount()), 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
